fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage 16-bit core (16 registers, 16-bit instructions, byte-addressed PC stepping by 2).
- Owns the PC, drives the single-cycle instruction memory, and applies the fetch/decode stall and decode-stage branch redirects.
- Latches fetched instructions into the decode stage and stops fetching on HLT.

---
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the 16-bit 5-stage core.
// Owns the PC and applies stall, decode-stage redirect and HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallFD,
  input  logic        branch_takenD,
  input  logic [15:0] branch_targetD,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] instrD,
  output logic [15:0] pc_plus2D,
  output logic        validD,
  output logic        haltF
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;
  logic        halt_q, halt_d;

  logic [15:0] pc_next;
  logic        hlt_f;

  assign pc_next = pc_q + 16'd2;
  assign hlt_f   = (imem_data[15:12] == HLT_OPCODE);

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    if (stallFD) begin
      // Hold everything; decode re-asserts any branch once the stall clears.
    end else if (branch_takenD) begin
      pc_d    = branch_targetD;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      halt_d  = 1'b0;
    end else if (halt_q) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d    = imem_data;
      pc_plus2_d = pc_next;
      valid_d    = 1'b1;
      if (hlt_f) begin
        halt_d = 1'b1;
      end else begin
        pc_d = pc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
    end
  end

  assign imem_addr = pc_q;
  assign instrD    = instr_q;
  assign pc_plus2D = pc_plus2_q;
  assign validD    = valid_q;
  assign haltF     = halt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a word-addressed instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallFD = 1'b0;
  logic        branch_takenD = 1'b0;
  logic [15:0] branch_targetD = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instrD;
  logic [15:0] pc_plus2D;
  logic        validD;
  logic        haltF;

  logic [15:0] mem [0:32767];
  int checks = 0;
  int errors = 0;

  assign imem_data = mem[imem_addr[15:1]];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stallFD       (stallFD),
    .branch_takenD (branch_takenD),
    .branch_targetD(branch_targetD),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instrD        (instrD),
    .pc_plus2D     (pc_plus2D),
    .validD        (validD),
    .haltF         (haltF)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stallFD = 1'b0;
    branch_takenD = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", imem_addr); end
    checks++; if (instrD !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instrD); end
    checks++; if (pc_plus2D !== 16'h0000) begin errors++; $display("FAIL reset_pc2 got %h want 0000", pc_plus2D); end
    checks++; if ({validD, haltF} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {validD, haltF}); end
  endtask

  task automatic test_free_run();
    logic [15:0] exp_i [4];
    exp_i = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({imem_addr, instrD, pc_plus2D, validD} !== {16'(2 * k + 2), exp_i[k], 16'(2 * k + 2), 1'b1}) begin
        errors++;
        $display("FAIL free_run[%0d] got pc=%h i=%h p2=%h v=%b want pc=%h i=%h p2=%h v=1", k,
                 imem_addr, instrD, pc_plus2D, validD, 16'(2 * k + 2), exp_i[k], 16'(2 * k + 2));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stallFD = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({imem_addr, instrD, validD} !== {16'h0004, 16'hA002, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got pc=%h i=%h v=%b want pc=0004 i=a002 v=1", k, imem_addr, instrD, validD);
      end
    end
    stallFD = 1'b0;
    step();
    checks++; if ({imem_addr, instrD} !== {16'h0006, 16'hA003}) begin errors++; $display("FAIL stall_release got pc=%h i=%h want 0006 a003", imem_addr, instrD); end
    step();
    checks++; if ({imem_addr, instrD} !== {16'h0008, 16'hA004}) begin errors++; $display("FAIL stall_next got pc=%h i=%h want 0008 a004", imem_addr, instrD); end
  endtask

  task automatic test_branch();
    do_reset();
    step(); step(); step();
    branch_takenD = 1'b1;
    branch_targetD = 16'h0100;
    step();
    branch_takenD = 1'b0;
    checks++; if ({imem_addr, instrD, validD} !== {16'h0100, 16'h0000, 1'b0}) begin errors++; $display("FAIL branch_bubble got pc=%h i=%h v=%b want 0100 0000 0", imem_addr, instrD, validD); end
    step();
    checks++; if ({imem_addr, instrD, pc_plus2D, validD} !== {16'h0102, 16'h1080, 16'h0102, 1'b1}) begin errors++; $display("FAIL branch_target got pc=%h i=%h p2=%h v=%b want 0102 1080 0102 1", imem_addr, instrD, pc_plus2D, validD); end
  endtask

  task automatic test_stall_branch();
    do_reset();
    step(); step();
    stallFD = 1'b1;
    branch_takenD = 1'b1;
    branch_targetD = 16'h0200;
    step();
    checks++; if ({imem_addr, instrD, validD} !== {16'h0004, 16'hA002, 1'b1}) begin errors++; $display("FAIL stall_branch_hold got pc=%h i=%h v=%b want 0004 a002 1", imem_addr, instrD, validD); end
    stallFD = 1'b0;
    step();
    branch_takenD = 1'b0;
    checks++; if ({imem_addr, instrD, validD} !== {16'h0200, 16'h0000, 1'b0}) begin errors++; $display("FAIL stall_branch_redirect got pc=%h i=%h v=%b want 0200 0000 0", imem_addr, instrD, validD); end
    step();
    checks++; if ({imem_addr, instrD, validD} !== {16'h0202, 16'h1100, 1'b1}) begin errors++; $display("FAIL stall_branch_after got pc=%h i=%h v=%b want 0202 1100 1", imem_addr, instrD, validD); end
  endtask

  task automatic test_halt();
    int bad;
    mem[5] = 16'hF000;
    do_reset();
    repeat (5) step();
    step();
    checks++; if ({imem_addr, instrD, pc_plus2D, validD, haltF} !== {16'h000A, 16'hF000, 16'h000C, 2'b11}) begin errors++; $display("FAIL halt_latch got pc=%h i=%h p2=%h v=%b h=%b want 000a f000 000c 1 1", imem_addr, instrD, pc_plus2D, validD, haltF); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if ({imem_addr, instrD, validD, haltF} !== {16'h000A, 16'h0000, 2'b01}) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL halt_frozen bad_cycles=%0d want 0 (last pc=%h v=%b h=%b)", bad, imem_addr, validD, haltF); end
    branch_takenD = 1'b1;
    branch_targetD = 16'h0040;
    step();
    branch_takenD = 1'b0;
    checks++; if ({imem_addr, validD, haltF} !== {16'h0040, 2'b00}) begin errors++; $display("FAIL halt_redirect got pc=%h v=%b h=%b want 0040 0 0", imem_addr, validD, haltF); end
    step();
    checks++; if ({instrD, validD} !== {16'h1020, 1'b1}) begin errors++; $display("FAIL halt_redirect_fetch got i=%h v=%b want 1020 1", instrD, validD); end
    // Re-enter halt, then reset mid-stream.
    branch_targetD = 16'h000A;
    branch_takenD = 1'b1;
    step();
    branch_takenD = 1'b0;
    step();
    checks++; if (haltF !== 1'b1) begin errors++; $display("FAIL halt_again got h=%b want 1", haltF); end
    do_reset();
    checks++; if ({imem_addr, validD, haltF} !== {16'h0000, 2'b00}) begin errors++; $display("FAIL halt_reset got pc=%h v=%b h=%b want 0000 0 0", imem_addr, validD, haltF); end
  endtask

  task automatic test_halt_squash();
    do_reset();
    repeat (5) step();
    branch_takenD = 1'b1;
    branch_targetD = 16'h0300;
    step();
    branch_takenD = 1'b0;
    checks++; if ({imem_addr, validD, haltF} !== {16'h0300, 2'b00}) begin errors++; $display("FAIL halt_squash got pc=%h v=%b h=%b want 0300 0 0", imem_addr, validD, haltF); end
    step();
    checks++; if ({instrD, validD, haltF} !== {16'h1180, 2'b10}) begin errors++; $display("FAIL halt_squash_next got i=%h v=%b h=%b want 1180 1 0", instrD, validD, haltF); end
    mem[5] = 16'h1005;
  endtask

  task automatic test_wrap();
    do_reset();
    branch_takenD = 1'b1;
    branch_targetD = 16'hFFFE;
    step();
    branch_takenD = 1'b0;
    checks++; if (imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_setup got pc=%h want fffe", imem_addr); end
    step();
    checks++; if ({imem_addr, instrD, pc_plus2D, validD} !== {16'h0000, 16'h1FFF, 16'h0000, 1'b1}) begin errors++; $display("FAIL wrap got pc=%h i=%h p2=%h v=%b want 0000 1fff 0000 1", imem_addr, instrD, pc_plus2D, validD); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 | 16'(i[11:0]);
    mem[0] = 16'hA001;
    mem[1] = 16'hA002;
    mem[2] = 16'hA003;
    mem[3] = 16'hA004;
    #1;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_stall_branch();
    test_halt();
    test_halt_squash();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
